// File: rtl/cci_mpf_prim_ooo_responder.sv
// ============================================================================
// cci_mpf_prim_ooo_responder
//
// Out-of-order responder model. It accepts tagged requests one per cycle and
// parks each one in a free slot with a countdown. When a slot's countdown
// reaches zero the slot competes in a rotating-priority arbiter. The winner
// is returned one cycle later on the rsp_* port. Responses therefore come
// back in an order scrambled by per-request latency and by the arbiter start
// point. Both of these can be randomized from a free-running LFSR.
//
// The output has no backpressure. This matches a reorder buffer whose
// payload write port is always ready.
//
// Ports
//   clk        in   clock
//   reset      in   synchronous, active-high reset; drops all pending work
//   random_en  in   1 = LFSR-randomized latency and arbiter start point
//   req_en     in   accept a request this cycle (only legal when notFull)
//   req_tag    in   request tag (ROB index), returned unchanged
//   req_data   in   request payload, returned unchanged
//   notFull    out  at least one free slot (from registered state)
//   numActive  out  number of occupied slots
//   rsp_valid  out  response valid this cycle; the consumer must take it
//   rsp_tag    out  tag of the response
//   rsp_data   out  payload of the response
// ============================================================================
module cci_mpf_prim_ooo_responder #(
    parameter int          N_ENTRIES         = 16,
    parameter int          N_TAG_BITS        = 5,
    parameter int          N_DATA_BITS       = 64,
    parameter int          MIN_LATENCY       = 2,
    parameter int          RAND_LATENCY_BITS = 4,
    parameter logic [15:0] LFSR_SEED         = 16'h1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          random_en,
    input  logic                          req_en,
    input  logic [N_TAG_BITS-1:0]         req_tag,
    input  logic [N_DATA_BITS-1:0]        req_data,
    output logic                          notFull,
    output logic [$clog2(N_ENTRIES):0]    numActive,
    output logic                          rsp_valid,
    output logic [N_TAG_BITS-1:0]         rsp_tag,
    output logic [N_DATA_BITS-1:0]        rsp_data
);

    localparam int IDX_BITS = $clog2(N_ENTRIES);
    // The width holds MIN_LATENCY plus the largest random extra. The load
    // sum therefore cannot overflow.
    localparam int CNT_BITS = $clog2(MIN_LATENCY + (1 << RAND_LATENCY_BITS)) + 1;
    localparam int ENT_BITS = N_TAG_BITS + N_DATA_BITS;
    // An all-zero Galois LFSR would lock up, so a zero seed becomes 1.
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'h1 : LFSR_SEED;

    typedef logic [IDX_BITS-1:0] idx_t;
    typedef logic [CNT_BITS-1:0] cnt_t;
    typedef logic [IDX_BITS:0]   num_t;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    // The wrap-around arbiter relies on natural index overflow. That only
    // works when N_ENTRIES is a power of 2.
    if (N_ENTRIES < 2 || (N_ENTRIES & (N_ENTRIES - 1)) != 0) begin : g_bad_entries
        $fatal(1, "cci_mpf_prim_ooo_responder: N_ENTRIES must be a power of 2 and at least 2");
    end

    if (RAND_LATENCY_BITS < 0 || RAND_LATENCY_BITS > 16) begin : g_bad_rand_bits
        $fatal(1, "cci_mpf_prim_ooo_responder: RAND_LATENCY_BITS must be 0..16");
    end

    if (MIN_LATENCY < 0) begin : g_bad_min_latency
        $fatal(1, "cci_mpf_prim_ooo_responder: MIN_LATENCY must be >= 0");
    end

    // ------------------------------------------------------------------
    // Free-running 16-bit Galois LFSR (mask 16'hB400)
    // ------------------------------------------------------------------
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q[0]) begin
            lfsr_d = (lfsr_q >> 1) ^ 16'hB400;
        end
    end

    // ------------------------------------------------------------------
    // Slot state
    // ------------------------------------------------------------------
    logic [N_ENTRIES-1:0] valid_q;
    logic [N_ENTRIES-1:0] valid_d;
    cnt_t                 cnt_q [N_ENTRIES];
    cnt_t                 cnt_d [N_ENTRIES];
    logic [N_ENTRIES-1:0] elig;

    num_t                 num_active_q;
    num_t                 num_active_d;

    logic                 rsp_valid_q;
    logic [ENT_BITS-1:0]  rsp_ent_q;

    // The tag and payload only need to be read for the single winner, so
    // they live in a memory array with a registered read port. The
    // registered read is also the output register.
    logic [ENT_BITS-1:0]  ent_mem [N_ENTRIES];

    logic                 accept;
    idx_t                 alloc_idx;
    idx_t                 start_idx;
    idx_t                 probe_idx;
    idx_t                 win_idx;
    logic                 win_valid;
    cnt_t                 rand_extra;
    cnt_t                 cnt_load;

    assign notFull   = (num_active_q != num_t'(N_ENTRIES));
    assign numActive = num_active_q;
    // A request while full is dropped. The assertion below reports it.
    assign accept    = req_en && notFull;

    // ------------------------------------------------------------------
    // Latency load value
    // ------------------------------------------------------------------
    if (RAND_LATENCY_BITS > 0) begin : g_rand_latency
        assign rand_extra = random_en ? cnt_t'(lfsr_q[RAND_LATENCY_BITS-1:0]) : '0;
    end else begin : g_fixed_latency
        assign rand_extra = '0;
    end

    assign cnt_load = cnt_t'(MIN_LATENCY) + rand_extra;

    // ------------------------------------------------------------------
    // Allocation: lowest-index slot that is free in the registered state.
    // A slot released this cycle is therefore not reused until next cycle.
    // ------------------------------------------------------------------
    always_comb begin
        alloc_idx = '0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                alloc_idx = idx_t'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbitration: first eligible slot at or after start_idx, with
    // wrap-around. The loop scans offsets from high to low, so the smallest
    // offset is assigned last and wins. The idx_t addition wraps modulo
    // N_ENTRIES by construction.
    // ------------------------------------------------------------------
    assign start_idx = random_en ? lfsr_q[15 -: IDX_BITS] : '0;

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        probe_idx = '0;
        for (int k = N_ENTRIES - 1; k >= 0; k--) begin
            probe_idx = start_idx + idx_t'(k);
            if (elig[probe_idx]) begin
                win_valid = 1'b1;
                win_idx   = probe_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-slot next state
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N_ENTRIES; gi++) begin : g_slot
        logic alloc_here;
        logic win_here;

        assign alloc_here = accept && (alloc_idx == idx_t'(gi));
        assign win_here   = win_valid && (win_idx == idx_t'(gi));
        assign elig[gi]   = valid_q[gi] && (cnt_q[gi] == '0);

        // Allocation only targets an invalid slot, and the winner is always
        // valid. The two can never hit the same slot in one cycle.
        assign valid_d[gi] = alloc_here ? 1'b1 : (valid_q[gi] && !win_here);
        assign cnt_d[gi]   = alloc_here            ? cnt_load :
                             (cnt_q[gi] != '0)     ? cnt_q[gi] - 1'b1 :
                                                     cnt_q[gi];
    end

    // Simultaneous accept and release leaves the count unchanged.
    assign num_active_d = num_active_q + num_t'(accept) - num_t'(win_valid);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q       <= SEED;
            valid_q      <= '0;
            num_active_q <= '0;
            rsp_valid_q  <= 1'b0;
            for (int i = 0; i < N_ENTRIES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            lfsr_q       <= lfsr_d;
            valid_q      <= valid_d;
            num_active_q <= num_active_d;
            rsp_valid_q  <= win_valid;
            for (int i = 0; i < N_ENTRIES; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Payload storage and registered read. Contents are don't-care while
    // the matching valid bit is clear, so no reset is needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            ent_mem[alloc_idx] <= {req_tag, req_data};
        end
        rsp_ent_q <= ent_mem[win_idx];
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_tag   = rsp_ent_q[ENT_BITS-1 -: N_TAG_BITS];
    assign rsp_data  = rsp_ent_q[N_DATA_BITS-1:0];

    // ------------------------------------------------------------------
    // Protocol check: the requester must honour notFull.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(req_en && !notFull))
                else $fatal(1, "cci_mpf_prim_ooo_responder: request while full, dropped");
        end
    end

endmodule

// File: tb/tb_cci_mpf_prim_ooo_responder.sv
module tb_cci_mpf_prim_ooo_responder;

    localparam int N    = 16;
    localparam int TW   = 5;
    localparam int DW   = 64;
    localparam int ML   = 2;
    localparam int ML32 = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset     = 1'b1;
    logic           random_en = 1'b0;
    logic           req_en    = 1'b0;
    logic           req_en32  = 1'b0;
    logic [TW-1:0]  req_tag   = '0;
    logic [DW-1:0]  req_data  = '0;

    logic           notFull,   notFull32;
    logic [4:0]     numActive, numActive32;
    logic           rsp_valid, rsp_valid32;
    logic [TW-1:0]  rsp_tag,   rsp_tag32;
    logic [DW-1:0]  rsp_data,  rsp_data32;

    cci_mpf_prim_ooo_responder #(
        .N_ENTRIES(N), .N_TAG_BITS(TW), .N_DATA_BITS(DW),
        .MIN_LATENCY(ML), .RAND_LATENCY_BITS(4), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset(reset), .random_en(random_en), .req_en(req_en),
        .req_tag(req_tag), .req_data(req_data), .notFull(notFull),
        .numActive(numActive), .rsp_valid(rsp_valid), .rsp_tag(rsp_tag),
        .rsp_data(rsp_data)
    );

    cci_mpf_prim_ooo_responder #(
        .N_ENTRIES(N), .N_TAG_BITS(TW), .N_DATA_BITS(DW),
        .MIN_LATENCY(ML32), .RAND_LATENCY_BITS(4), .LFSR_SEED(16'h1)
    ) dut32 (
        .clk(clk), .reset(reset), .random_en(random_en), .req_en(req_en32),
        .req_tag(req_tag), .req_data(req_data), .notFull(notFull32),
        .numActive(numActive32), .rsp_valid(rsp_valid32), .rsp_tag(rsp_tag32),
        .rsp_data(rsp_data32)
    );

    typedef struct {
        int            cyc;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } exp_t;

    exp_t q[$];     // timed expectations for dut (deterministic tests)
    exp_t q32[$];   // timed expectations for dut32
    exp_t pend[$];  // outstanding random requests; cyc = issue cycle

    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int ooo      = 0;
    bit rand_mode = 1'b0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
            else begin
                bad++;
                $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", name, obs, exp, cyc);
            end
    endtask

    // Compares this cycle's outputs against the scoreboards.
    task automatic check_rsp();
        int idx;
        int lat;
        if (rand_mode) begin
            if (rsp_valid === 1'b1) begin
                idx = -1;
                foreach (pend[i]) begin
                    if (idx < 0 && pend[i].data === rsp_data) idx = i;
                end
                chk("rnd_match", 64'(idx >= 0), 64'd1);
                if (idx >= 0) begin
                    lat = cyc - pend[idx].cyc;
                    chk("rnd_tag", 64'(rsp_tag), 64'(pend[idx].tag));
                    chk("rnd_lat_lo", 64'(lat >= ML + 2), 64'd1);
                    chk("rnd_lat_hi", 64'(lat <= ML + 2 + 15 + N), 64'd1);
                    if (idx != 0) ooo++;
                    pend.delete(idx);
                end
            end
        end else begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
                chk("rsp_valid", 64'(rsp_valid), 64'd1);
                chk("rsp_tag", 64'(rsp_tag), 64'(q[0].tag));
                chk("rsp_data", rsp_data, q[0].data);
                void'(q.pop_front());
            end else begin
                chk("rsp_idle", 64'(rsp_valid), 64'd0);
            end
        end
        if (q32.size() > 0 && q32[0].cyc == cyc) begin
            chk("rsp32_valid", 64'(rsp_valid32), 64'd1);
            chk("rsp32_tag", 64'(rsp_tag32), 64'(q32[0].tag));
            chk("rsp32_data", rsp_data32, q32[0].data);
            void'(q32.pop_front());
        end else begin
            chk("rsp32_idle", 64'(rsp_valid32), 64'd0);
        end
    endtask

    // Called at the negedge of cycle cyc: check outputs, drive inputs that are
    // sampled at the edge closing this cycle, then move to the next cycle.
    task automatic step(input bit en, input bit en32, input logic [TW-1:0] tag,
                        input logic [DW-1:0] data);
        check_rsp();
        req_en   = en;
        req_en32 = en32;
        req_tag  = tag;
        req_data = data;
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        req_en   = 1'b0;
        req_en32 = 1'b0;
        q.delete();
        q32.delete();
        pend.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        int guard;
        logic [TW-1:0] t;
        logic [DW-1:0] d;

        // ---- single request, fixed latency ----
        do_reset();
        chk("reset_numActive", 64'(numActive), 64'd0);
        chk("reset_notFull", 64'(notFull), 64'd1);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        q.push_back('{4, 5'd5, 64'hA5});
        for (int c = 0; c < 8; c++) begin
            chk("single_numActive", 64'(numActive), (c >= 1 && c <= 3) ? 64'd1 : 64'd0);
            step(c == 0, 1'b0, 5'd5, 64'hA5);
        end
        chk("single_drained", 64'(q.size()), 64'd0);

        // ---- back-to-back tags 0..15 ----
        do_reset();
        for (int i = 0; i < 16; i++) q.push_back('{i + 4, TW'(i), 64'hB000 + 64'(i)});
        for (int c = 0; c < 22; c++) begin
            chk("b2b_notFull", 64'(notFull), 64'd1);
            step(c < 16, 1'b0, TW'(c), 64'hB000 + 64'(c));
        end
        chk("b2b_drained", 64'(q.size()), 64'd0);

        // ---- fill with MIN_LATENCY=32 ----
        do_reset();
        for (int i = 0; i < 16; i++) q32.push_back('{i + 34, TW'(i), 64'hD000 + 64'(i)});
        for (int c = 0; c < 52; c++) begin
            chk("fill_notFull", 64'(notFull32), (c >= 16 && c <= 33) ? 64'd0 : 64'd1);
            if (c == 16) chk("fill_numActive", 64'(numActive32), 64'd16);
            step(1'b0, c < 16, TW'(c), 64'hD000 + 64'(c));
        end
        chk("fill_drained", 64'(q32.size()), 64'd0);

        // ---- slot reuse: tags 3, 7, then 9 into freed slot 0 ----
        do_reset();
        q.push_back('{4, 5'd3, 64'h33});
        q.push_back('{5, 5'd7, 64'h77});
        q.push_back('{9, 5'd9, 64'h99});
        for (int c = 0; c < 12; c++) begin
            if (c == 0)      step(1'b1, 1'b0, 5'd3, 64'h33);
            else if (c == 1) step(1'b1, 1'b0, 5'd7, 64'h77);
            else if (c == 5) step(1'b1, 1'b0, 5'd9, 64'h99);
            else             step(1'b0, 1'b0, '0, '0);
        end
        chk("reuse_drained", 64'(q.size()), 64'd0);

        // ---- randomized latency and arbitration ----
        random_en = 1'b1;
        do_reset();
        rand_mode = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, '0, '0);
            guard = 0;
            while (notFull !== 1'b1 && guard < 64) begin
                step(1'b0, 1'b0, '0, '0);
                guard++;
            end
            chk("rnd_room", 64'(notFull), 64'd1);
            if (notFull === 1'b1) begin
                t = TW'($urandom);
                d = {32'(n), 32'($urandom)};
                pend.push_back('{cyc, t, d});
                step(1'b1, 1'b0, t, d);
            end
        end
        guard = 0;
        while (pend.size() > 0 && guard < 200) begin
            step(1'b0, 1'b0, '0, '0);
            guard++;
        end
        chk("rnd_drain", 64'(pend.size()), 64'd0);
        chk("rnd_out_of_order", 64'(ooo > 0), 64'd1);
        rand_mode = 1'b0;
        random_en = 1'b0;

        // ---- reset mid-operation with 4 pending (MIN_LATENCY=32) ----
        do_reset();
        for (int c = 0; c < 60; c++) begin
            reset = (c == 6);
            if (c == 6) chk("midrst_before", 64'(numActive32), 64'd4);
            if (c >= 7) begin
                chk("midrst_numActive", 64'(numActive32), 64'd0);
                chk("midrst_notFull", 64'(notFull32), 64'd1);
            end
            step(1'b0, c < 4, TW'(c), 64'hE000 + 64'(c));
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
